mat_rd_streamer: RTL and testbench
==================================

MAT_RD_STREAMER -- requirements
Module: mat_rd_streamer

Interface
REQ-001 SHALL have parameter ADDR_LEN, default 16, RAM address width.
REQ-002 SHALL have parameter DATA_LEN, default 8, RAM word width.
REQ-003 SHALL have parameter DIM_LEN, default 8, width of row/column count and stride fields.
REQ-004 SHALL have ports, clock and reset first:
- CLK  in  1  single clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command pulse, sampled only in IDLE.
- base_addr  in  ADDR_LEN  matrix element (0,0) address.
- num_rows  in  DIM_LEN  row count.
- num_cols  in  DIM_LEN  column count.
- row_stride  in  DIM_LEN  address distance between consecutive rows.
- rd_addr  out  ADDR_LEN  RAM read address.
- rd_Q  in  DATA_LEN  RAM registered read data, valid one cycle after rd_addr.
- out_data  out  DATA_LEN  streamed element.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when out_valid and out_ready both high.
- out_eol  out  1  element is last of its inner-loop line.
- out_last  out  1  element is last of the matrix.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the final element is accepted.

Function
REQ-005 SHALL implement FSM IDLE -> RUN on start; RUN -> DRAIN after the final address is issued; DRAIN -> IDLE when the final element is accepted.
REQ-006 SHALL latch base_addr, num_rows, num_cols, row_stride on start; later input changes SHALL have no effect on the active job.
REQ-007 SHALL compute element address as base_addr + r*row_stride + c, truncated modulo 2**ADDR_LEN (wrap-around is legal).
REQ-008 SHALL traverse row-major by default: c is the inner loop, r the outer loop.
REQ-009 SHALL issue at most one address per cycle, and only when (FIFO occupancy + in-flight reads) < 2.
REQ-010 SHALL push rd_Q into a 2-entry output FIFO exactly one cycle after the address was issued, tagged with eol/last flags.
REQ-011 SHALL drive out_valid whenever the FIFO is non-empty; out_data, out_eol and out_last SHALL be held stable while out_valid is high and out_ready is low.
REQ-012 SHALL sustain one element per cycle with out_ready held high; first out_valid SHALL appear 2 cycles after start.
REQ-013 SHALL handle num_rows==0 or num_cols==0 as follows: no reads issued, done pulsed the cycle after start, return to IDLE.
REQ-014 SHALL ignore start while busy.
REQ-015 SHALL handle simultaneous FIFO push and pop on a full FIFO: the pop frees space for the push in the same cycle, so no data is lost.

Reset
REQ-016 SHALL, on RST, drive state IDLE, rd_addr 0, out_valid 0, out_data 0, out_eol 0, out_last 0, busy 0, done 0, and empty the FIFO.
REQ-017 SHALL, on RST mid-job, discard in-flight reads and leave no trace of the aborted job after reset release.

Configuration
REQ-018 SHALL support macro MFA_RD_TRANSPOSE_EN: when defined, an extra input transpose (1 bit) is latched on start, and when set the traversal is column-major (r inner), with out_eol marking column end; when undefined, the port is absent and traversal is row-major only.

Structure
REQ-019 SHALL take shared package mfa_pkg, which holds the FSM state enum, the default widths ADDR_LEN/DATA_LEN/DIM_LEN, and the FIFO entry struct {data, eol, last}.
REQ-020 SHALL place the 2-entry output FIFO in sub-module mat_rd_fifo.

Verification
REQ-021 SHALL verify: base 0, 2x3, stride 3, out_ready=1 -> addresses 0..5, six beats on consecutive cycles, eol on beats 3 and 6, last+done on beat 6.
REQ-022 SHALL verify: base 0x10, 3x2, stride 4 -> addresses 0x10,0x11,0x14,0x15,0x18,0x19.
REQ-023 SHALL verify: out_ready toggling 1,0,0,1 during a 4x4 job -> 16 beats in order, data stable while stalled, no loss or duplication.
REQ-024 SHALL verify: base 0xFFFE, 1x4 -> addresses 0xFFFE,0xFFFF,0x0000,0x0001.
REQ-025 SHALL verify: num_cols=0 -> zero beats, done one cycle after start; RST asserted mid 4x4 job -> all outputs 0, and the next job streams cleanly.
REQ-026 SHALL verify, with MFA_RD_TRANSPOSE_EN defined and transpose=1: 2x3, stride 3 -> addresses 0,3,1,4,2,5, eol on beats 2, 4 and 6.

Source files
------------

// File: rtl/mfa_pkg.sv
// mfa_pkg: shared widths, FSM states and output FIFO entry for the matrix read streamer
package mfa_pkg;
  localparam int ADDR_LEN = 16;
  localparam int DATA_LEN = 8;
  localparam int DIM_LEN  = 8;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic [DATA_LEN-1:0] data;
    logic                eol;
    logic                last;
  } fifo_entry_t;
endpackage

// File: rtl/mat_rd_fifo.sv
// mat_rd_fifo: 2-entry output FIFO; a pop frees a full FIFO for a push in the same cycle
module mat_rd_fifo
  import mfa_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_push,
  input  fifo_entry_t i_din,
  input  logic        i_pop,
  output fifo_entry_t o_head,
  output logic [1:0]  o_cnt
);
  fifo_entry_t r_mem [2];
  logic        r_wp;
  logic        r_rp;
  logic [1:0]  r_cnt;
  logic        w_push;
  logic        w_pop;
  assign w_pop  = i_pop && r_cnt != 2'd0;
  assign w_push = i_push && (r_cnt != 2'd2 || w_pop);
  assign o_head = r_mem[r_rp];
  assign o_cnt  = r_cnt;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) r_mem[r_wp] <= i_din;
      r_wp  <= r_wp ^ w_push;
      r_rp  <= r_rp ^ w_pop;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
endmodule

// File: rtl/mat_rd_streamer.sv
// mat_rd_streamer: streams a strided matrix out of a registered-read RAM through a 2-entry FIFO
// MFA_RD_TRANSPOSE_EN adds a transpose input selecting column-major traversal
module mat_rd_streamer
  import mfa_pkg::*;
#(
  parameter int ADDR_LEN = mfa_pkg::ADDR_LEN,
  parameter int DATA_LEN = mfa_pkg::DATA_LEN,
  parameter int DIM_LEN  = mfa_pkg::DIM_LEN
)(
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic [ADDR_LEN-1:0] base_addr,
  input  logic [DIM_LEN-1:0]  num_rows,
  input  logic [DIM_LEN-1:0]  num_cols,
  input  logic [DIM_LEN-1:0]  row_stride,
`ifdef MFA_RD_TRANSPOSE_EN
  input  logic                transpose,
`endif
  output logic [ADDR_LEN-1:0] rd_addr,
  input  logic [DATA_LEN-1:0] rd_Q,
  output logic [DATA_LEN-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_eol,
  output logic                out_last,
  output logic                busy,
  output logic                done
);
  state_t              r_state;
  logic [ADDR_LEN-1:0] r_line;
  logic [ADDR_LEN-1:0] r_in_step;
  logic [ADDR_LEN-1:0] r_out_step;
  logic [DIM_LEN-1:0]  r_i;
  logic [DIM_LEN-1:0]  r_o;
  logic [DIM_LEN-1:0]  r_in_n;
  logic [DIM_LEN-1:0]  r_out_n;
  logic                r_inflight;
  logic                r_if_eol;
  logic                r_if_last;
  logic                r_done;
  logic                w_tr;
  logic                w_pop;
  logic                w_issue;
  logic                w_eol;
  logic                w_last;
  logic [1:0]          w_cnt;
  logic [DIM_LEN-1:0]  w_in_n;
  logic [DIM_LEN-1:0]  w_out_n;
  logic [ADDR_LEN-1:0] w_stride;
  logic [ADDR_LEN-1:0] w_next_line;
  fifo_entry_t         w_head;
  fifo_entry_t         w_din;
`ifdef MFA_RD_TRANSPOSE_EN
  assign w_tr = transpose;
`else
  assign w_tr = 1'b0;
`endif
  assign w_stride    = ADDR_LEN'(row_stride);
  assign w_in_n      = w_tr ? num_rows : num_cols;
  assign w_out_n     = w_tr ? num_cols : num_rows;
  assign w_next_line = r_line + r_out_step;
  assign w_eol       = r_i == r_in_n - DIM_LEN'(1);
  assign w_last      = w_eol && r_o == r_out_n - DIM_LEN'(1);
  assign w_pop       = out_valid && out_ready;
  // a same-cycle pop counts as free space, which keeps one beat per cycle flowing
  assign w_issue     = r_state == RUN && ({1'b0, r_inflight} + w_cnt - {1'b0, w_pop}) < 2'd2;
  assign w_din       = '{data: rd_Q, eol: r_if_eol, last: r_if_last};
  assign out_valid   = w_cnt != 2'd0;
  assign out_data    = w_head.data;
  assign out_eol     = w_head.eol;
  assign out_last    = w_head.last;
  assign busy        = r_state != IDLE;
  assign done        = r_done;
  mat_rd_fifo u_fifo (
    .CLK    (CLK),
    .RST    (RST),
    .i_push (r_inflight),
    .i_din  (w_din),
    .i_pop  (w_pop),
    .o_head (w_head),
    .o_cnt  (w_cnt)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      rd_addr    <= '0;
      r_line     <= '0;
      r_in_step  <= '0;
      r_out_step <= '0;
      r_i        <= '0;
      r_o        <= '0;
      r_in_n     <= '0;
      r_out_n    <= '0;
      r_inflight <= 1'b0;
      r_if_eol   <= 1'b0;
      r_if_last  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_if_eol  <= w_eol;
        r_if_last <= w_last;
      end
      case (r_state)
        IDLE: if (start) begin
          r_state    <= (w_in_n == '0 || w_out_n == '0) ? DRAIN : RUN;
          rd_addr    <= base_addr;
          r_line     <= base_addr;
          r_in_step  <= w_tr ? w_stride : ADDR_LEN'(1);
          r_out_step <= w_tr ? ADDR_LEN'(1) : w_stride;
          r_in_n     <= w_in_n;
          r_out_n    <= w_out_n;
          r_i        <= '0;
          r_o        <= '0;
        end
        RUN: if (w_issue) begin
          if (w_last) r_state <= DRAIN;
          if (w_eol) begin
            r_i     <= '0;
            r_o     <= r_o + DIM_LEN'(1);
            r_line  <= w_next_line;
            rd_addr <= w_next_line;
          end else begin
            r_i     <= r_i + DIM_LEN'(1);
            rd_addr <= rd_addr + r_in_step;
          end
        end
        // an empty job reaches here with nothing queued and finishes one cycle after start
        default: if ((w_pop && w_head.last) || (w_cnt == 2'd0 && !r_inflight)) begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mat_rd_streamer.sv
// tb_mat_rd_streamer: random and directed jobs checked against a loop-nest model of the matrix walk
module tb_mat_rd_streamer;
  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [15:0] base_addr;
  logic [7:0]  num_rows;
  logic [7:0]  num_cols;
  logic [7:0]  row_stride;
`ifdef MFA_RD_TRANSPOSE_EN
  logic        transpose;
`endif
  logic [15:0] rd_addr;
  logic [7:0]  rd_Q;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_eol;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [7:0]  mem [0:65535];
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [15:0] a;
    bit          eol;
    bit          last;
  } exp_t;

  always #5 CLK = ~CLK;
  always @(posedge CLK) rd_Q <= mem[rd_addr];

  mat_rd_streamer dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .base_addr  (base_addr),
    .num_rows   (num_rows),
    .num_cols   (num_cols),
    .row_stride (row_stride),
`ifdef MFA_RD_TRANSPOSE_EN
    .transpose  (transpose),
`endif
    .rd_addr    (rd_addr),
    .rd_Q       (rd_Q),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_eol    (out_eol),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int n);
    logic [3:0] p = 4'b1001;
    return mode == 0 ? 1'b1 : mode == 1 ? p[n % 4] : 1'($urandom_range(0, 1));
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_eol"}, out_eol, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // rmode: 0 ready high, 1 ready pattern 1,0,0,1, 2 random ready plus a start pulse while busy
  task automatic run_job(input logic [15:0] base, input logic [7:0] rows, input logic [7:0] cols,
                         input logic [7:0] stride, input bit tr, input int rmode, input int abort_at);
    exp_t q[$];
    exp_t e;
    int in_n, out_n, n, first_n, last_n, done_n, beats, total;
    bit stalled;
    logic [7:0] sd;
    logic se, sl;
    in_n  = tr ? int'(rows) : int'(cols);
    out_n = tr ? int'(cols) : int'(rows);
    for (int o = 0; o < out_n; o++)
      for (int i = 0; i < in_n; i++) begin
        int r, c;
        r = tr ? i : o;
        c = tr ? o : i;
        q.push_back('{a: 16'(int'(base) + r * int'(stride) + c), eol: i == in_n - 1,
                      last: i == in_n - 1 && o == out_n - 1});
      end
    total = q.size();
    @(negedge CLK);
    start = 1'b1; base_addr = base; num_rows = rows; num_cols = cols; row_stride = stride;
`ifdef MFA_RD_TRANSPOSE_EN
    transpose = tr;
`endif
    @(negedge CLK);
    start = 1'b0; base_addr = 16'($urandom); num_rows = 8'($urandom); num_cols = 8'($urandom);
    row_stride = 8'($urandom);
`ifdef MFA_RD_TRANSPOSE_EN
    transpose = 1'($urandom);
`endif
    out_ready = rdy(rmode, 0);
    chk("busy_after_start", busy, 1);
    chk("valid_too_early", out_valid, 0);
    n = 0; first_n = -1; last_n = -1; done_n = -1; beats = 0; stalled = 0; sd = 0; se = 0; sl = 0;
    while (done_n < 0 && n < 400) begin
      @(negedge CLK);
      n++;
      if (abort_at == n) break;
      start = rmode == 2 && n == 3 && total >= 4;
      out_ready = rdy(rmode, n);
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, sd);
        chk("stall_eol", out_eol, se);
        chk("stall_last", out_last, sl);
      end
      if (done) begin
        done_n = n;
        chk("busy_at_done", busy, 0);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("extra_beat", beats, total);
        else begin
          e = q.pop_front();
          chk($sformatf("data_b%0d", beats), out_data, mem[e.a]);
          chk($sformatf("eol_b%0d", beats), out_eol, e.eol);
          chk($sformatf("last_b%0d", beats), out_last, e.last);
        end
        if (first_n < 0) first_n = n;
        if (out_last) last_n = n;
        beats++;
      end
      stalled = out_valid && !out_ready;
      sd = out_data; se = out_eol; sl = out_last;
    end
    start = 1'b0;
    if (abort_at == n) return;
    chk("done_seen", done_n > 0, 1);
    chk("beat_count", beats, total);
    if (total == 0) chk("empty_done_cycle", done_n, 1);
    else chk("done_after_last", done_n, last_n + 1);
    if (rmode == 0 && total > 0) begin
      chk("first_latency", first_n, 2);
      chk("back_to_back", last_n - first_n, total - 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    RST = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0; num_cols = '0; row_stride = '0;
    out_ready = 1'b0;
`ifdef MFA_RD_TRANSPOSE_EN
    transpose = 1'b0;
`endif
    repeat (3) @(negedge CLK);
    chk_idle_outputs("reset");
    RST = 1'b0;
    run_job(16'h0000, 8'd2, 8'd3, 8'd3, 1'b0, 0, 0);
    run_job(16'h0010, 8'd3, 8'd2, 8'd4, 1'b0, 0, 0);
    run_job(16'h0000, 8'd4, 8'd4, 8'd4, 1'b0, 1, 0);
    run_job(16'hFFFE, 8'd1, 8'd4, 8'd9, 1'b0, 0, 0);
    run_job(16'h0123, 8'd3, 8'd0, 8'd2, 1'b0, 0, 0);
    run_job(16'h0200, 8'd4, 8'd4, 8'd5, 1'b0, 2, 6);
    RST = 1'b1;
    @(negedge CLK);
    chk_idle_outputs("mid_reset");
    @(negedge CLK);
    RST = 1'b0;
    chk_idle_outputs("reset_release");
    run_job(16'h0300, 8'd4, 8'd4, 8'd4, 1'b0, 0, 0);
`ifdef MFA_RD_TRANSPOSE_EN
    run_job(16'h0000, 8'd2, 8'd3, 8'd3, 1'b1, 0, 0);
`endif
    for (int t = 0; t < 30; t++) begin
      bit tr = 1'b0;
`ifdef MFA_RD_TRANSPOSE_EN
      tr = 1'($urandom);
`endif
      run_job(16'($urandom), 8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)),
              8'($urandom_range(0, 8)), tr, $urandom_range(0, 2), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
